clk_en_scheduler: RTL and testbench

//  Single-clock replacement for derived-clock division: emits a one-cycle clock-enable (tick) every
//  DIV cycles of clk, plus a phase bit that alternates fetch (0) / data (1) slots of the femtoRV32 core
//  on its shared memory. Provides run/halt/single-step sequencing and glitch-free runtime divisor updates.

---
 rtl/clk_en_scheduler.sv | 138 +++++++++++++
 tb/tb_clk_en_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_en_scheduler.sv
// Clock-enable scheduler: one-cycle tick every d cycles with fetch/data phase and run/halt/step.
// Define CLK_SCHED_TICKCNT_EN to add the free-running tick_cnt_o counter.
module clk_en_scheduler #(
    parameter int unsigned CNT_W     = 28,
    parameter int unsigned DIV_RESET = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic             step_i,
    input  logic             div_wr_i,
    input  logic [CNT_W-1:0] div_in_i,
    output logic             tick_o,
    output logic             phase_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] div_cur_o
`ifdef CLK_SCHED_TICKCNT_EN
    ,
    output logic [31:0]      tick_cnt_o
`endif
);

    localparam logic [CNT_W-1:0] DivRst = CNT_W'(DIV_RESET);
    localparam logic [CNT_W-1:0] One    = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pvld_q, pvld_d;
    logic             tick_q, tick_d;
    logic             phase_q, phase_d;
    logic [CNT_W-1:0] d_eff;
    logic             wrap;

    // A zero divisor behaves as one so the compare below always terminates.
    assign d_eff = (div_q == '0) ? One : div_q;
    assign wrap  = (state_q != IDLE) && (cnt_q == d_eff - One);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        pend_d  = pend_q;
        pvld_d  = pvld_q;
        tick_d  = 1'b0;
        phase_d = phase_q;
        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                pvld_d = 1'b0;
                if (div_wr_i) begin
                    div_d = div_in_i;
                end
                if (run_i) begin
                    state_d = RUN;
                end else if (step_i) begin
                    state_d = STEP;
                end
            end
            RUN, STEP: begin
                if (wrap) begin
                    cnt_d   = '0;
                    tick_d  = 1'b1;
                    phase_d = ~phase_q;
                    pvld_d  = 1'b0;
                    // A write on the boundary edge beats an older pending one.
                    if (div_wr_i) begin
                        div_d = div_in_i;
                    end else if (pvld_q) begin
                        div_d = pend_q;
                    end
                    if (state_q == STEP || !run_i) begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + One;
                    if (div_wr_i) begin
                        pend_d = div_in_i;
                        pvld_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= DivRst;
            pend_q  <= '0;
            pvld_q  <= 1'b0;
            tick_q  <= 1'b0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
            pvld_q  <= pvld_d;
            tick_q  <= tick_d;
            phase_q <= phase_d;
        end
    end

`ifdef CLK_SCHED_TICKCNT_EN
    logic [31:0] tick_cnt_q, tick_cnt_d;

    assign tick_cnt_d = wrap ? tick_cnt_q + 32'd1 : tick_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign tick_cnt_o = tick_cnt_q;
`endif

    assign tick_o    = tick_q;
    assign phase_o   = phase_q;
    assign busy_o    = (state_q != IDLE);
    assign div_cur_o = div_q;

endmodule

// File: tb/tb_clk_en_scheduler.sv
// Bench for clk_en_scheduler: directed scenarios plus randomized run/step/divisor traffic
// checked against an event-time reference model.
module tb_clk_en_scheduler;

    localparam int CW = 28;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic          step = 1'b0;
    logic          div_wr = 1'b0;
    logic [CW-1:0] div_in = '0;
    logic          tick_o;
    logic          phase_o;
    logic          busy_o;
    logic [CW-1:0] div_cur_o;
`ifdef CLK_SCHED_TICKCNT_EN
    logic [31:0]   tick_cnt_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    clk_en_scheduler #(.CNT_W(CW), .DIV_RESET(2)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .run_i     (run),
        .step_i    (step),
        .div_wr_i  (div_wr),
        .div_in_i  (div_in),
        .tick_o    (tick_o),
        .phase_o   (phase_o),
        .busy_o    (busy_o),
        .div_cur_o (div_cur_o)
`ifdef CLK_SCHED_TICKCNT_EN
        ,
        .tick_cnt_o(tick_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: tracks the absolute edge number of the next due tick
    // instead of a cycle counter.
    longint        n_edge = 0;
    longint        m_due = 0;
    int            m_act = 0;   // 0 idle, 1 running, 2 single step
    logic [CW-1:0] m_div = 2;
    logic [CW-1:0] m_pend = '0;
    bit            m_pvld = 0;
    logic          m_tick = 0;
    logic          m_phase = 0;
    logic [31:0]   m_tcnt = 0;

    function automatic longint eff(input logic [CW-1:0] v);
        return (v == 0) ? 1 : longint'(v);
    endfunction

    function automatic logic [CW+2:0] mvec();
        return {m_tick, m_phase, (m_act != 0), m_div};
    endfunction

    task automatic model_edge();
        n_edge++;
        if (rst) begin
            m_act = 0; m_tick = 0; m_phase = 0;
            m_div = 2; m_pvld = 0; m_tcnt = 0;
            return;
        end
        m_tick = 0;
        if (m_act == 0) begin
            if (div_wr) m_div = div_in;
            if (run) begin
                m_act = 1; m_due = n_edge + eff(m_div);
            end else if (step) begin
                m_act = 2; m_due = n_edge + eff(m_div);
            end
        end else if (n_edge == m_due) begin
            m_tick = 1;
            m_phase = ~m_phase;
            m_tcnt = m_tcnt + 1;
            if (div_wr) m_div = div_in;
            else if (m_pvld) m_div = m_pend;
            m_pvld = 0;
            if (m_act == 2 || !run) m_act = 0;
            else m_due = n_edge + eff(m_div);
        end else if (div_wr) begin
            m_pend = div_in;
            m_pvld = 1;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1; run = 0; step = 0; div_wr = 0;
        cyc(); cyc();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({tick_o, phase_o, busy_o, div_cur_o} !== {3'b000, CW'(2)}) begin
            n_fail++;
            $display("FAIL reset_state: got %h exp %h",
                     {tick_o, phase_o, busy_o, div_cur_o}, {3'b000, CW'(2)});
        end
        n_tests++;
        if ({tick_o, phase_o, busy_o, div_cur_o} !== mvec()) begin
            n_fail++;
            $display("FAIL reset_model: got %h exp %h",
                     {tick_o, phase_o, busy_o, div_cur_o}, mvec());
        end
    endtask

    task automatic test_run_default();
        logic et, ep;
        do_reset();
        run = 1;
        for (int k = 0; k <= 8; k++) begin
            cyc();
            et = (k >= 2) && (k % 2 == 0);
            ep = ((k / 2) % 2) == 1;
            n_tests++;
            if (tick_o !== et || phase_o !== ep || busy_o !== 1'b1) begin
                n_fail++;
                $display("FAIL run_default k=%0d: got t%b p%b b%b exp t%b p%b b1",
                         k, tick_o, phase_o, busy_o, et, ep);
            end
        end
    endtask

    task automatic test_div_update();
        int tq[$];
        int gexp[5] = '{5, 5, 5, 3, 3};
        do_reset();
        div_wr = 1; div_in = 5;
        cyc();
        div_wr = 0; run = 1;
        cyc();
        for (int k = 1; k <= 30; k++) begin
            div_wr = (k == 12);
            div_in = 3;
            cyc();
            if (tick_o === 1'b1) tq.push_back(k);
            n_tests++;
            if ({tick_o, phase_o, busy_o, div_cur_o} !== mvec()) begin
                n_fail++;
                $display("FAIL div_update_model k=%0d: got %h exp %h",
                         k, {tick_o, phase_o, busy_o, div_cur_o}, mvec());
            end
        end
        div_wr = 0;
        n_tests++;
        if (tq.size() < 5) begin
            n_fail++;
            $display("FAIL div_update_count: got %0d ticks exp >=5", tq.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                int g;
                g = (i == 0) ? tq[0] : tq[i] - tq[i-1];
                n_tests++;
                if (g !== gexp[i]) begin
                    n_fail++;
                    $display("FAIL div_update_gap%0d: got %0d exp %0d", i, g, gexp[i]);
                end
            end
        end
    endtask

    task automatic test_halt();
        int nt, pos;
        bit seen;
        do_reset();
        div_wr = 1; div_in = 4;
        cyc();
        div_wr = 0; run = 1;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            cyc();
            if (tick_o === 1'b1) seen = 1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL halt_wait: got no tick exp tick within 20 cycles");
        end
        run = 0;
        nt = 0; pos = 0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (tick_o === 1'b1) begin nt++; pos = k; end
        end
        n_tests++;
        if (nt !== 1 || pos !== 4) begin
            n_fail++;
            $display("FAIL halt_last_tick: got %0d ticks at %0d exp 1 at 4", nt, pos);
        end
        n_tests++;
        if (busy_o !== 1'b0 || {tick_o, phase_o, busy_o, div_cur_o} !== mvec()) begin
            n_fail++;
            $display("FAIL halt_idle: got %h exp %h",
                     {tick_o, phase_o, busy_o, div_cur_o}, mvec());
        end
    endtask

    task automatic test_step();
        int nt, pos;
        do_reset();
        div_wr = 1; div_in = 3;
        cyc();
        div_wr = 0; step = 1;
        cyc();
        step = 0;
        nt = 0; pos = 0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            if (tick_o === 1'b1) begin nt++; pos = k; end
        end
        n_tests++;
        if (nt !== 1 || pos !== 3 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL step_single: got %0d ticks at %0d busy %b exp 1 at 3 busy 0",
                     nt, pos, busy_o);
        end
        run = 1;
        for (int k = 0; k < 16; k++) begin
            step = (k == 5);
            cyc();
            n_tests++;
            if ({tick_o, phase_o, busy_o, div_cur_o} !== mvec()) begin
                n_fail++;
                $display("FAIL step_in_run k=%0d: got %h exp %h",
                         k, {tick_o, phase_o, busy_o, div_cur_o}, mvec());
            end
        end
        step = 0;
    endtask

    task automatic test_div_zero_reset();
        do_reset();
        div_wr = 1; div_in = 0;
        cyc();
        div_wr = 0;
        n_tests++;
        if (div_cur_o !== '0) begin
            n_fail++;
            $display("FAIL div_zero_cur: got %0d exp 0", div_cur_o);
        end
        run = 1;
        cyc();
        for (int k = 1; k <= 6; k++) begin
            cyc();
            n_tests++;
            if (tick_o !== 1'b1) begin
                n_fail++;
                $display("FAIL div_zero_tick k=%0d: got %b exp 1", k, tick_o);
            end
        end
        div_wr = 1; div_in = 5;
        cyc();
        div_wr = 0;
        cyc(); cyc();
        rst = 1;
        cyc();
        rst = 0;
        n_tests++;
        if ({tick_o, phase_o, busy_o, div_cur_o} !== {3'b000, CW'(2)}) begin
            n_fail++;
            $display("FAIL mid_reset: got %h exp %h",
                     {tick_o, phase_o, busy_o, div_cur_o}, {3'b000, CW'(2)});
        end
        run = 0;
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 800; k++) begin
            rst    = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 9) == 0) run = ~run;
            step   = ($urandom_range(0, 6) == 0);
            div_wr = ($urandom_range(0, 9) == 0);
            div_in = CW'($urandom_range(0, 6));
            cyc();
            n_tests++;
            if ({tick_o, phase_o, busy_o, div_cur_o} !== mvec()) begin
                n_fail++;
                $display("FAIL random k=%0d: got %h exp %h",
                         k, {tick_o, phase_o, busy_o, div_cur_o}, mvec());
            end
`ifdef CLK_SCHED_TICKCNT_EN
            n_tests++;
            if (tick_cnt_o !== m_tcnt) begin
                n_fail++;
                $display("FAIL random_tcnt k=%0d: got %0d exp %0d", k, tick_cnt_o, m_tcnt);
            end
`endif
        end
        rst = 0; run = 0; step = 0; div_wr = 0;
    endtask

`ifdef CLK_SCHED_TICKCNT_EN
    task automatic test_tickcnt();
        do_reset();
        div_wr = 1; div_in = 1;
        cyc();
        div_wr = 0; run = 1;
        for (int k = 0; k < 11; k++) cyc();
        n_tests++;
        if (tick_cnt_o !== 32'd10) begin
            n_fail++;
            $display("FAIL tickcnt_ten: got %0d exp 10", tick_cnt_o);
        end
        force dut.tick_cnt_q = 32'hFFFF_FFFD;
        #1;
        release dut.tick_cnt_q;
        m_tcnt = 32'hFFFF_FFFD;
        for (int k = 0; k < 5; k++) begin
            cyc();
            n_tests++;
            if (tick_cnt_o !== m_tcnt) begin
                n_fail++;
                $display("FAIL tickcnt_wrap k=%0d: got %h exp %h", k, tick_cnt_o, m_tcnt);
            end
        end
        n_tests++;
        if (tick_cnt_o !== 32'd2) begin
            n_fail++;
            $display("FAIL tickcnt_final: got %h exp 2", tick_cnt_o);
        end
        run = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_run_default();
        test_div_update();
        test_halt();
        test_step();
        test_div_zero_reset();
        test_random();
`ifdef CLK_SCHED_TICKCNT_EN
        test_tickcnt();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
